// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified RAM port arbiter: access sizes, FSM
// states, the IO region tag and the latched request bundle.
package mem_arbiter_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BEAT = 2'd1;
   localparam logic [1:0] S_TAIL = 2'd2;

   // addr[17:16] == IO_REGION marks uncacheable IO space
   localparam logic [1:0] IO_REGION = 2'b11;

   typedef struct packed {
      logic        is_mem;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // index of the last byte beat for a size code
   function automatic logic [1:0] last_beat(input logic [1:0] size);
      logic [1:0] r;
      case (size)
         SZ_HALF: r = 2'd1;
         SZ_WORD: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   function automatic logic is_io(input logic [1:0] region);
      return region == IO_REGION;
   endfunction

   function automatic logic aligned(input logic [1:0] off,
                                    input logic [1:0] size);
      return (off & last_beat(size)) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_arbiter_byte_merge.sv
// Byte insert: replaces bytes off..off+n-1 of base with data bytes 0..n-1.
// Ports: base/data in 32, off in 2, size in 2 (size code), word out 32.
module mem_arbiter_byte_merge
   import mem_arbiter_pkg::*;
(
   input  logic [31:0] base,
   input  logic [31:0] data,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   output logic [31:0] word
);

   always_comb begin
      word = base;
      for (int j = 0; j < 4; j++) begin
         if (j >= int'(off) &&
             (j - int'(off)) <= int'(last_beat(size)))
            word[8*j +: 8] = data[8*(j - int'(off)) +: 8];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Owner of the 8-bit RAM port: IF/MEM arbitration, byte-beat serialisation
// and dcache sequencing (lookup, fill, write-through).
// Ports: clk/rst/rdy; if_* fetch side; mem_* load/store side;
// dc_* dcache lookup/update; ram_* byte-wide RAM/IO bus.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_done_o,
   output logic [31:0] if_inst_o,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [1:0]  mem_size_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic        mem_done_o,
   output logic [31:0] mem_rdata_o,
   output logic [31:0] dc_raddr_o,
   input  logic        dc_hit_i,
   input  logic [31:0] dc_data_i,
   output logic        dc_we_o,
   output logic [31:0] dc_waddr_o,
   output logic [31:0] dc_wdata_o,
   output logic [31:0] ram_a_o,
   output logic        ram_wr_o,
   output logic [7:0]  ram_dout_o,
   input  logic [7:0]  ram_din_i
);

   logic [1:0]  state;
   logic [1:0]  cnt;
   req_t        req;
   logic        sh_hit;
   logic [31:0] sh_word;
   logic [31:0] rbuf;
   logic        rd_vld;
   logic [1:0]  rd_idx;

   logic        mem_ok;
   logic        if_ok;
   logic        mem_hit;
   logic        busy;
   logic        req_cache;
   logic [1:0]  last;
   logic [31:0] rd_word;
   logic [31:0] st_word;

   // a requester is blocked during its own done cycle
   assign mem_ok = mem_req_i & ~mem_done_o;
   assign if_ok  = if_req_i & ~if_done_o;

   assign dc_raddr_o = mem_addr_i;
   assign mem_hit = mem_ok & ~mem_we_i & (mem_size_i == SZ_WORD) &
                    ~is_io(mem_addr_i[17:16]) &
                    aligned(mem_addr_i[1:0], mem_size_i) & dc_hit_i;

   assign busy = (state == S_BEAT) || (state == S_TAIL);
   assign last = last_beat(req.size);
   assign req_cache = ~is_io(req.addr[17:16]) &
                      aligned(req.addr[1:0], req.size);

   // TAIL keeps presenting the last byte so its data stays valid
   // across a rdy stall
   assign ram_a_o    = busy ? req.addr + 32'(cnt) : 32'h0;
   assign ram_wr_o   = rdy & (state == S_BEAT) & req.we;
   assign ram_dout_o = (state == S_BEAT && req.we) ?
                       req.wdata[{cnt, 3'b000} +: 8] : 8'h00;

   mem_arbiter_byte_merge u_rd_merge (
      .base (rbuf),
      .data ({24'h0, ram_din_i}),
      .off  (rd_idx),
      .size (SZ_BYTE),
      .word (rd_word)
   );

   mem_arbiter_byte_merge u_st_merge (
      .base (sh_word),
      .data (req.wdata),
      .off  (req.addr[1:0]),
      .size (req.size),
      .word (st_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= 2'd0;
         req         <= '0;
         sh_hit      <= 1'b0;
         sh_word     <= 32'h0;
         rbuf        <= 32'h0;
         rd_vld      <= 1'b0;
         rd_idx      <= 2'd0;
         if_done_o   <= 1'b0;
         if_inst_o   <= 32'h0;
         mem_done_o  <= 1'b0;
         mem_rdata_o <= 32'h0;
         dc_we_o     <= 1'b0;
         dc_waddr_o  <= 32'h0;
         dc_wdata_o  <= 32'h0;
      end else begin
         // rd_vld/rd_idx track which byte ram_din_i holds; they follow
         // the RAM even while rdy is low so no byte is misplaced
         rd_vld <= busy & ~req.we;
         rd_idx <= cnt;
         if (rd_vld)
            rbuf[{rd_idx, 3'b000} +: 8] <= ram_din_i;

         if (rdy) begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            dc_we_o    <= 1'b0;
            unique case (state)
               S_IDLE: begin
                  cnt <= 2'd0;
                  if (mem_ok) begin
                     if (mem_hit) begin
                        mem_done_o  <= 1'b1;
                        mem_rdata_o <= dc_data_i;
                     end else begin
                        req <= '{is_mem: 1'b1, we: mem_we_i,
                                 size: mem_size_i, addr: mem_addr_i,
                                 wdata: mem_wdata_i};
                        sh_hit  <= dc_hit_i;
                        sh_word <= dc_data_i;
                        rbuf    <= 32'h0;
                        state   <= S_BEAT;
                     end
                  end else if (if_ok) begin
                     req <= '{is_mem: 1'b0, we: 1'b0,
                              size: SZ_WORD, addr: if_addr_i,
                              wdata: 32'h0};
                     sh_hit <= 1'b0;
                     rbuf   <= 32'h0;
                     state  <= S_BEAT;
                  end
               end
               S_BEAT: begin
                  if (cnt != last) begin
                     cnt <= cnt + 2'd1;
                  end else if (!req.we) begin
                     state <= S_TAIL;
                  end else begin
                     state      <= S_IDLE;
                     mem_done_o <= 1'b1;
                     if (req_cache && req.size == SZ_WORD) begin
                        dc_we_o    <= 1'b1;
                        dc_waddr_o <= req.addr;
                        dc_wdata_o <= req.wdata;
                     end else if (req_cache && sh_hit) begin
                        dc_we_o    <= 1'b1;
                        dc_waddr_o <= {req.addr[31:2], 2'b00};
                        dc_wdata_o <= st_word;
                     end
                  end
               end
               S_TAIL: begin
                  state <= S_IDLE;
                  if (req.is_mem) begin
                     mem_done_o  <= 1'b1;
                     mem_rdata_o <= rd_word;
                     if (req_cache && req.size == SZ_WORD) begin
                        dc_we_o    <= 1'b1;
                        dc_waddr_o <= req.addr;
                        dc_wdata_o <= rd_word;
                     end
                  end else begin
                     if_done_o <= 1'b1;
                     if_inst_o <= rd_word;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
